coefficient_loader: RTL and testbench

Write-side sequencer for the 7×7 coefficient shift-register file. It accepts a host coefficient stream through a valid/ready handshake for a 3×3, 5×5 or 7×7 kernel. It issues exactly MASK_WIDTH² `wr_en`/`wr_data` writes in raster order, zero-filling the positions outside a centred smaller kernel. It pulses `done` once the full coefficient set is visible on the file's output bus.

---
 rtl/coefficient_loader_if.sv | 37 +++
 rtl/coefficient_loader.sv | 162 ++++++++++++++++
 tb/tb_coefficient_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/coefficient_loader_if.sv
// ----------------------------------------------------------------------------
// coefficient_loader_if
// Bundles the host stream, the control/status lines and the coefficient-file
// write port of the coefficient loader.
//   start     host -> loader  load request
//   ksize     host -> loader  kernel size code (0=3x3, 1=5x5, 2/3=7x7)
//   in_valid  host -> loader  coefficient valid
//   in_data   host -> loader  coefficient, raster order
//   in_ready  loader -> host  coefficient accepted this cycle
//   wr_en     loader -> file  shift-write strobe
//   wr_data   loader -> file  shift-write data
//   busy      loader -> host  load in progress
//   done      loader -> host  one-cycle completion pulse
// ----------------------------------------------------------------------------
interface coefficient_loader_if #(
    parameter int COFCNT_BIT = 16
);
    logic                  start;
    logic [1:0]            ksize;
    logic                  in_valid;
    logic [COFCNT_BIT-1:0] in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [COFCNT_BIT-1:0] wr_data;
    logic                  busy;
    logic                  done;

    modport master (
        output start, ksize, in_valid, in_data,
        input  in_ready, wr_en, wr_data, busy, done
    );

    modport slave (
        input  start, ksize, in_valid, in_data,
        output in_ready, wr_en, wr_data, busy, done
    );
endinterface

// File: rtl/coefficient_loader.sv
// ----------------------------------------------------------------------------
// coefficient_loader
// Write-side sequencer for the MASK_WIDTH x MASK_WIDTH coefficient shift file.
// Walks every file position in raster order, taking a host coefficient for
// positions inside the centred KxK kernel and writing zero elsewhere, so one
// load always issues exactly MASK_WIDTH^2 shift writes and fully overwrites
// the file.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    coefficient_loader_if.slave (host stream, status, file write port)
// ----------------------------------------------------------------------------
module coefficient_loader #(
    parameter int COFCNT_BIT = 16,
    parameter int MASK_WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    coefficient_loader_if.slave    bus
);

    localparam int POS_W = $clog2(MASK_WIDTH);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(MASK_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                state_q;
    logic [1:0]            ksize_q;
    logic [POS_W-1:0]      row_q;
    logic [POS_W-1:0]      col_q;
    logic                  in_ready_q;
    logic                  wr_en_q;
    logic [COFCNT_BIT-1:0] wr_data_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  inside_s;
    logic                  step_s;
    logic                  last_s;
    logic [POS_W-1:0]      row_d;
    logic [POS_W-1:0]      col_d;

    // True when (r, c) lies in the centred kernel selected by ks; codes 2 and
    // 3 both select the full mask so every position is inside.
    function automatic logic inside_f(input logic [POS_W-1:0] r,
                                      input logic [POS_W-1:0] c,
                                      input logic [1:0]       ks);
        logic [POS_W-1:0] lo;
        logic [POS_W-1:0] hi;
        case (ks)
            2'd0:    lo = POS_W'((MASK_WIDTH - 3) / 2);
            2'd1:    lo = POS_W'((MASK_WIDTH - 5) / 2);
            default: lo = POS_W'((MASK_WIDTH - 7) / 2);
        endcase
        hi = LAST_POS - lo;
        return (r >= lo) && (r <= hi) && (c >= lo) && (c <= hi);
    endfunction

    // Current-position decode and next raster position (col-first).
    always_comb begin
        inside_s = inside_f(row_q, col_q, ksize_q);
        // Outside positions advance every cycle; inside ones only on a fire.
        step_s   = (state_q == ST_LOAD) && (inside_s ? bus.in_valid : 1'b1);
        last_s   = (row_q == LAST_POS) && (col_q == LAST_POS);
        if (col_q == LAST_POS) begin
            col_d = '0;
            row_d = row_q + POS_W'(1'b1);
        end else begin
            col_d = col_q + POS_W'(1'b1);
            row_d = row_q;
        end
    end

    // Sequencer state, position counters and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ksize_q    <= 2'd0;
            row_q      <= '0;
            col_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    wr_en_q   <= 1'b0;
                    wr_data_q <= '0;
                    done_q    <= 1'b0;
                    if (bus.start) begin
                        state_q    <= ST_LOAD;
                        ksize_q    <= bus.ksize;
                        row_q      <= '0;
                        col_q      <= '0;
                        busy_q     <= 1'b1;
                        // in_ready is registered, so it is pre-decoded for
                        // the position the next cycle will present.
                        in_ready_q <= inside_f('0, '0, bus.ksize);
                    end else begin
                        busy_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (step_s) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= inside_s ? bus.in_data : '0;
                        if (last_s) begin
                            state_q    <= ST_FLUSH;
                            row_q      <= '0;
                            col_q      <= '0;
                            in_ready_q <= 1'b0;
                        end else begin
                            row_q      <= row_d;
                            col_q      <= col_d;
                            in_ready_q <= inside_f(row_d, col_d, ksize_q);
                        end
                    end else begin
                        // Stall: hold position and in_ready, issue no write.
                        wr_en_q   <= 1'b0;
                        wr_data_q <= '0;
                    end
                end
                ST_FLUSH: begin
                    // The final write is on the bus this cycle; the file has
                    // taken it by the time done is seen.
                    state_q   <= ST_DONE;
                    wr_en_q   <= 1'b0;
                    wr_data_q <= '0;
                    done_q    <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    wr_en_q    <= 1'b0;
                    wr_data_q  <= '0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_coefficient_loader.sv
// ----------------------------------------------------------------------------
// tb_coefficient_loader
// Directed bench for coefficient_loader. A behavioural model of the 7x7
// coefficient shift file captures every write so slot contents can be
// compared against hand-derived kernel images.
// ----------------------------------------------------------------------------
module tb_coefficient_loader;

    localparam int W  = 16;
    localparam int MW = 7;
    localparam int NS = MW * MW;

    logic clk;
    logic reset;

    coefficient_loader_if #(.COFCNT_BIT(W)) bus ();

    coefficient_loader #(.COFCNT_BIT(W), .MASK_WIDTH(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coefficient file: new data enters the top slot and shifts down, so
    // write n of a full load ends in slot n.
    logic [W*NS-1:0] file_q;
    always @(posedge clk) begin
        if (bus.wr_en) file_q <= {bus.wr_data, file_q[W*NS-1:W]};
    end

    int checks = 0;
    int fails  = 0;

    // Per-load observations.
    int fires, writes, first_wr, last_wr, done_cyc, ready_cnt, busy_cnt, bad_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] slot(input int n);
        return file_q[W*n +: W];
    endfunction

    // Expected slot value for a load of kernel code ks with beats base, base+1...
    function automatic logic [W-1:0] exp_slot(input logic [1:0] ks, input logic [W-1:0] base, input int n);
        int k, o, r, c;
        k = (ks == 2'd0) ? 3 : (ks == 2'd1) ? 5 : 7;
        o = (MW - k) / 2;
        r = n / MW;
        c = n % MW;
        if (r >= o && r <= o + k - 1 && c >= o && c <= o + k - 1)
            return base + W'((r - o) * k + (c - o));
        return '0;
    endfunction

    function automatic int image_errors(input logic [1:0] ks, input logic [W-1:0] base);
        int bad = 0;
        for (int n = 0; n < NS; n++)
            if (slot(n) !== exp_slot(ks, base, n)) bad++;
        return bad;
    endfunction

    // One load. alt: in_valid low on odd cycles. abort_at>0: pull reset once
    // that many beats have been taken. poke: start pulsed in cycles 10 and 51.
    task automatic run_load(input logic [1:0] ks, input logic [W-1:0] base,
                            input bit alt, input int abort_at, input bit poke);
        int beat = 0;
        bit prev_fire = 1'b0;
        bit fire;
        fires = 0; writes = 0; first_wr = -1; last_wr = -1; done_cyc = -1;
        ready_cnt = 0; busy_cnt = 0; bad_wr = 0;
        bus.start    = 1'b1;
        bus.ksize    = ks;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 200; c++) begin
            bus.in_valid = alt ? (c % 2 == 0) : 1'b1;
            bus.in_data  = base + W'(beat);
            bus.start    = poke && (c == 10 || c == 51);
            @(negedge clk);
            if (abort_at > 0 && fires == abort_at) begin
                reset = 1'b0;
                #1;
                check("abort_in_ready", 32'(bus.in_ready), 32'd0);
                check("abort_wr_en",    32'(bus.wr_en),    32'd0);
                check("abort_wr_data",  32'(bus.wr_data),  32'd0);
                check("abort_busy",     32'(bus.busy),     32'd0);
                check("abort_done",     32'(bus.done),     32'd0);
                #2;
                reset = 1'b1;
                bus.in_valid = 1'b0;
                return;
            end
            fire = bus.in_valid && bus.in_ready;
            if (fire) begin
                fires++;
                beat++;
            end
            if (bus.in_ready) ready_cnt++;
            if (bus.busy) busy_cnt++;
            if (bus.wr_en) begin
                writes++;
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                if (!prev_fire) bad_wr++;
            end
            prev_fire = fire;
            if (bus.done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int bad;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.ksize    = 2'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_wr_en",    32'(bus.wr_en),    32'd0);
        check("rst_wr_data",  32'(bus.wr_data),  32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        #10;
        reset = 1'b1;

        // 7x7, data 1..49, continuous valid
        run_load(2'd2, 16'd1, 1'b0, 0, 1'b0);
        check("k7_first_wr",  32'(first_wr),  32'd2);
        check("k7_last_wr",   32'(last_wr),   32'd50);
        check("k7_writes",    32'(writes),    32'd49);
        check("k7_done_cyc",  32'(done_cyc),  32'd51);
        check("k7_busy_cnt",  32'(busy_cnt),  32'd51);
        check("k7_ready_cnt", 32'(ready_cnt), 32'd49);
        check("k7_fires",     32'(fires),     32'd49);
        check("k7_slot0",     32'(slot(0)),   32'd1);
        check("k7_slot48",    32'(slot(48)),  32'd49);
        check("k7_image",     32'(image_errors(2'd2, 16'd1)), 32'd0);

        // 3x3, data 1..9
        run_load(2'd0, 16'd1, 1'b0, 0, 1'b0);
        check("k3_fires",     32'(fires),     32'd9);
        check("k3_ready_cnt", 32'(ready_cnt), 32'd9);
        check("k3_writes",    32'(writes),    32'd49);
        check("k3_done_cyc",  32'(done_cyc),  32'd51);
        check("k3_slot16",    32'(slot(16)),  32'd1);
        check("k3_slot18",    32'(slot(18)),  32'd3);
        check("k3_slot32",    32'(slot(32)),  32'd9);
        check("k3_image",     32'(image_errors(2'd0, 16'd1)), 32'd0);

        // 5x5, data 0x8001..0x8019
        run_load(2'd1, 16'h8001, 1'b0, 0, 1'b0);
        check("k5_fires",  32'(fires),    32'd25);
        check("k5_slot8",  32'(slot(8)),  32'h8001);
        check("k5_slot40", 32'(slot(40)), 32'h8019);
        bad = 0;
        for (int n = 0; n < NS; n++)
            if ((n / MW == 0 || n / MW == MW - 1 || n % MW == 0 || n % MW == MW - 1) && slot(n) !== 16'h0000)
                bad++;
        check("k5_border_zero", 32'(bad), 32'd0);
        check("k5_image", 32'(image_errors(2'd1, 16'h8001)), 32'd0);

        // 7x7 with in_valid alternating (low first)
        run_load(2'd2, 16'd1, 1'b1, 0, 1'b0);
        check("alt_writes",   32'(writes),   32'd49);
        check("alt_fires",    32'(fires),    32'd49);
        check("alt_bad_wr",   32'(bad_wr),   32'd0);
        check("alt_done_cyc", 32'(done_cyc), 32'd100);
        check("alt_image",    32'(image_errors(2'd2, 16'd1)), 32'd0);

        // Reset after beat 20 of a 7x7 load, then a clean 3x3 load
        run_load(2'd2, 16'd100, 1'b0, 20, 1'b0);
        run_load(2'd0, 16'd1, 1'b0, 0, 1'b0);
        check("rl_fires",    32'(fires),    32'd9);
        check("rl_done_cyc", 32'(done_cyc), 32'd51);
        check("rl_image",    32'(image_errors(2'd0, 16'd1)), 32'd0);

        // ksize=3 with start poked during LOAD and during DONE
        run_load(2'd3, 16'd1, 1'b0, 0, 1'b1);
        check("pk_fires",    32'(fires),    32'd49);
        check("pk_done_cyc", 32'(done_cyc), 32'd51);
        check("pk_image",    32'(image_errors(2'd3, 16'd1)), 32'd0);
        @(negedge clk);
        check("pk_busy_after1",  32'(bus.busy),     32'd0);
        check("pk_ready_after1", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("pk_busy_after2",  32'(bus.busy),  32'd0);
        check("pk_wr_en_after2", 32'(bus.wr_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
